// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch front end
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int PC_STEP    = 4;
    localparam int R15_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : DEPTH-entry circular prefetch buffer with synchronous flush
// Revision   : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ENTRY_T                 din,
    output ENTRY_T                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    ENTRY_T          mem_q [DEPTH];
    ENTRY_T          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush wins over any push/pop on the same edge.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : fetch-PC FSM, req/ack instruction port and prefetch buffer
// Revision   : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_target,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [XLEN-1:0]        imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_plus8,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  target;
    logic             push, pop;
    logic [CW-1:0]    fifo_count, count_next;
    entry_t           push_entry, head;

    assign target     = redirect_target & ~XLEN'(1);
    assign out_valid  = (fifo_count != '0);
    assign push       = (state_q == REQ) && imem_ack && !redirect;
    assign pop        = out_valid && out_ready && !redirect;
    assign count_next = redirect ? '0 : (fifo_count + CW'(push) - CW'(pop));
    assign push_entry = '{instr: imem_rdata, pc: addr_q};

    // A new request is only issued when the slot it will fill is already free.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end else if (count_next < DEPTH_C) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                    if (count_next < DEPTH_C) begin
                        addr_d = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_d = target;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .head  (head),
        .count (fifo_count)
    );

    assign imem_req     = (state_q != IDLE);
    assign imem_addr    = addr_q;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus8 = head.pc + XLEN'(R15_OFFSET);
    assign count        = fifo_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : vector table, corner sequences and random run vs. a queue model
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_ready = 1'b0;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_instr, out_pc, out_pc_plus8;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus8    (out_pc_plus8),
        .count           (count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of delivered words plus one outstanding-fetch slot.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    bit          m_busy, m_keep;
    logic [31:0] m_addr, m_pc;

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_keep = 0;
        m_addr = RESET_PC; m_pc = RESET_PC;
    endtask

    task automatic model_step(input bit rd, input logic [31:0] tgt, input bit ak,
                              input logic [31:0] rdat, input bit rdy);
        bit   was_busy = m_busy;
        bit   was_keep = m_keep;
        bit   can_issue;
        ent_t e;
        if (rd) begin
            mq.delete();
            m_pc = tgt & 32'hFFFF_FFFE;
            if (was_busy && ak) m_busy = 0;
            else if (was_busy)  m_keep = 0;
        end else begin
            can_issue = !was_busy;
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (was_busy && ak) begin
                m_busy = 0;
                if (was_keep) begin
                    e.instr = rdat; e.pc = m_addr;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                    can_issue = 1;
                end
            end
            if (can_issue && mq.size() < DEPTH) begin
                m_busy = 1; m_keep = 1; m_addr = m_pc;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".req"}, 32'(imem_req), 32'(m_busy));
        if (m_busy) chk({tag, ".addr"}, imem_addr, m_addr);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, ".instr"}, out_instr, mq[0].instr);
            chk({tag, ".pc"}, out_pc, mq[0].pc);
            chk({tag, ".pc8"}, out_pc_plus8, mq[0].pc + 32'd8);
        end
    endtask

    // Called at a falling edge: apply inputs, advance model across the rising edge.
    task automatic drive(input bit rd, input logic [31:0] tgt, input bit ak,
                         input logic [31:0] rdat, input bit rdy);
        redirect = rd; redirect_target = tgt; imem_ack = ak;
        imem_rdata = rdat; out_ready = rdy;
        @(posedge clk);
        model_step(rd, tgt, ak, rdat, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; redirect = 1'b0; redirect_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    typedef struct {
        bit rd; logic [31:0] tgt; bit ack; logic [31:0] rdata; bit rdy;
        bit e_req; logic [31:0] e_addr; logic [2:0] e_cnt; logic [31:0] e_pc; logic [31:0] e_instr;
    } vec_t;
    vec_t vt[16];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // rd tgt ack rdata rdy | req addr cnt pc instr  (row = inputs, outputs seen before them)
        vt[0]  = '{0, 32'h0,   0, 32'h0,         0,  0, 32'h0,   3'd0, 32'h0,   32'h0};
        vt[1]  = '{0, 32'h0,   1, 32'hE000_0000, 0,  1, 32'h0,   3'd0, 32'h0,   32'h0};
        vt[2]  = '{0, 32'h0,   1, 32'hE000_0001, 0,  1, 32'h4,   3'd1, 32'h0,   32'hE000_0000};
        vt[3]  = '{0, 32'h0,   1, 32'hE000_0002, 0,  1, 32'h8,   3'd2, 32'h0,   32'hE000_0000};
        vt[4]  = '{0, 32'h0,   1, 32'hE000_0003, 0,  1, 32'hC,   3'd3, 32'h0,   32'hE000_0000};
        vt[5]  = '{0, 32'h0,   0, 32'h0,         0,  0, 32'h0,   3'd4, 32'h0,   32'hE000_0000};
        vt[6]  = '{0, 32'h0,   0, 32'h0,         1,  0, 32'h0,   3'd4, 32'h0,   32'hE000_0000};
        vt[7]  = '{0, 32'h0,   1, 32'hE000_0004, 1,  1, 32'h10,  3'd3, 32'h4,   32'hE000_0001};
        vt[8]  = '{0, 32'h0,   1, 32'hE000_0005, 1,  1, 32'h14,  3'd3, 32'h8,   32'hE000_0002};
        vt[9]  = '{0, 32'h0,   0, 32'h0,         1,  1, 32'h18,  3'd3, 32'hC,   32'hE000_0003};
        vt[10] = '{0, 32'h0,   0, 32'h0,         0,  1, 32'h18,  3'd2, 32'h10,  32'hE000_0004};
        vt[11] = '{1, 32'h101, 0, 32'h0,         1,  1, 32'h18,  3'd2, 32'h10,  32'hE000_0004};
        vt[12] = '{0, 32'h0,   1, 32'h0000_DEAD, 1,  1, 32'h18,  3'd0, 32'h0,   32'h0};
        vt[13] = '{0, 32'h0,   0, 32'h0,         1,  0, 32'h0,   3'd0, 32'h0,   32'h0};
        vt[14] = '{0, 32'h0,   1, 32'hE000_0006, 0,  1, 32'h100, 3'd0, 32'h0,   32'h0};
        vt[15] = '{0, 32'h0,   0, 32'h0,         0,  1, 32'h104, 3'd1, 32'h100, 32'hE000_0006};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", imem_addr, RESET_PC);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.pc", out_pc, 32'd0);
        chk("rst.pc8", out_pc_plus8, 32'd8);
        chk("rst.count", 32'(count), 32'd0);
        model_reset();
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tbl%0d.req", i), 32'(imem_req), 32'(vt[i].e_req));
            if (vt[i].e_req) chk($sformatf("tbl%0d.addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("tbl%0d.count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(vt[i].e_cnt != 0));
            if (vt[i].e_cnt != 0) begin
                chk($sformatf("tbl%0d.pc", i), out_pc, vt[i].e_pc);
                chk($sformatf("tbl%0d.instr", i), out_instr, vt[i].e_instr);
                chk($sformatf("tbl%0d.pc8", i), out_pc_plus8, vt[i].e_pc + 32'd8);
            end
            drive(vt[i].rd, vt[i].tgt, vt[i].ack, vt[i].rdata, vt[i].rdy);
        end

        // Redirect with no fetch in flight (buffer full, FSM idle)
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check_model("fill");
            drive(0, 0, m_busy, 32'hC000_0000 + i, 0);
        end
        chk("fill.count", 32'(count), 32'd4);
        chk("fill.req", 32'(imem_req), 32'd0);
        drive(1, 32'h101, 0, 0, 1);
        chk("redirA.count", 32'(count), 32'd0);
        chk("redirA.req", 32'(imem_req), 32'd0);
        drive(0, 0, 0, 0, 1);
        chk("redirA.req1", 32'(imem_req), 32'd1);
        chk("redirA.addr", imem_addr, 32'h100);
        drive(0, 0, 1, 32'h1234_5678, 1);
        chk("redirA.pc", out_pc, 32'h100);
        chk("redirA.pc8", out_pc_plus8, 32'h108);
        check_model("redirA");

        // Redirect while the fetch of 0x8 waits; ack arrives three cycles later
        do_reset();
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'hB000_0000, 1);
        drive(0, 0, 1, 32'hB000_0004, 1);
        chk("redirB.addr", imem_addr, 32'h8);
        drive(1, 32'h200, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("redirB.hold%0d", k), imem_addr, 32'h8);
            check_model("redirB");
            drive(0, 0, (k == 2), 32'hBAD0_0008, 1);
        end
        chk("redirB.req0", 32'(imem_req), 32'd0);
        chk("redirB.valid0", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0, 1);
        chk("redirB.addr2", imem_addr, 32'h200);
        drive(0, 0, 1, 32'h2000_0000, 1);
        chk("redirB.pc", out_pc, 32'h200);
        chk("redirB.instr", out_instr, 32'h2000_0000);

        // Redirect coincident with the ack of 0xC
        do_reset();
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 32'hC000_0000 + k, 1);
        chk("redirC.addr", imem_addr, 32'hC);
        drive(1, 32'h300, 1, 32'hBAD0_000C, 1);
        chk("redirC.req0", 32'(imem_req), 32'd0);
        chk("redirC.count", 32'(count), 32'd0);
        drive(0, 0, 0, 0, 1);
        chk("redirC.addr2", imem_addr, 32'h300);
        drive(0, 0, 1, 32'h3000_0000, 1);
        chk("redirC.pc", out_pc, 32'h300);

        // Randomised traffic, including targets near the top of the address space
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            check_model("rnd");
            drive(($urandom_range(0, 15) == 0), tgt, m_busy && ($urandom_range(0, 2) != 0),
                  $urandom, ($urandom_range(0, 3) != 0));
        end
        check_model("rnd_end");

        // Asynchronous reset in the middle of a request with three entries buffered
        do_reset();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 32'hD000_0000 + k, 0);
        chk("arst.pre_count", 32'(count), 32'd3);
        chk("arst.pre_req", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst.req", 32'(imem_req), 32'd0);
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
